dma_read_streamer: RTL

DMA_READ_STREAMER -- requirements
Module: dma_read_streamer

---
 rtl/dma_read_streamer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/dma_read_streamer.sv
// DMA read streamer: fetches len words over a Wishbone classic read port
// and forwards them through a small FIFO onto a valid/ready stream.
module dma_read_streamer #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] src_addr,
   input  logic [15:0] len,
   output logic        busy,
   output logic        done,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [3:0]  wb_sel_o,
   output logic [31:0] wb_adr_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   output logic        m_tvalid,
   output logic [31:0] m_tdata,
   output logic        m_tlast,
   input  logic        m_tready
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [2:0] {IDLE, REQ, GAP, WAIT, DRAIN} state_e;

   state_e           state_q;
   logic             stb_q;
   logic             busy_q;
   logic             done_q;
   logic [31:0]      addr_q;
   logic [15:0]      remaining_q;

   logic [31:0]      fifo_data_q [FIFO_DEPTH];
   logic             fifo_last_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   logic             push;
   logic             pop;
   logic             fifo_empty;
   logic             fifo_full;
   logic             head_last;
   logic             last_pop;
   logic             last_tag;
   logic             addr_lsb_unused;

   // Word alignment is forced, so the two low address bits are never used.
   assign addr_lsb_unused = ^src_addr[1:0];

   assign push       = (state_q == REQ) && wb_ack_i;
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign pop        = !fifo_empty && m_tready;
   assign head_last  = fifo_last_q[rd_ptr_q];
   assign last_pop   = pop && head_last;
   assign last_tag   = (remaining_q == 16'd1);

   assign busy     = busy_q;
   assign done     = done_q;
   assign wb_cyc_o = stb_q;
   assign wb_stb_o = stb_q;
   assign wb_we_o  = 1'b0;
   assign wb_sel_o = 4'hF;
   assign wb_adr_o = addr_q;

   // Head data is gated so the stream outputs read zero whenever the FIFO is empty.
   assign m_tvalid = !fifo_empty;
   assign m_tdata  = fifo_empty ? 32'h0 : fifo_data_q[rd_ptr_q];
   assign m_tlast  = !fifo_empty && head_last;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data_q[wr_ptr_q] <= wb_dat_i;
         fifo_last_q[wr_ptr_q] <= last_tag;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
      end
   end

   // The last word may already leave the FIFO during GAP, so completion is
   // detected there as well as in DRAIN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         stb_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         addr_q      <= 32'h0;
         remaining_q <= 16'h0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  addr_q      <= {src_addr[31:2], 2'b00};
                  remaining_q <= len;
                  if (len == 16'h0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q <= REQ;
                     stb_q   <= 1'b1;
                     busy_q  <= 1'b1;
                  end
               end
            end
            REQ: begin
               if (wb_ack_i) begin
                  addr_q      <= addr_q + 32'd4;
                  remaining_q <= remaining_q - 16'd1;
                  stb_q       <= 1'b0;
                  state_q     <= GAP;
               end
            end
            GAP: begin
               if (remaining_q == 16'h0) begin
                  if (last_pop) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= DRAIN;
                  end
               end else if (!fifo_full) begin
                  state_q <= REQ;
                  stb_q   <= 1'b1;
               end else begin
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (!fifo_full) begin
                  state_q <= REQ;
                  stb_q   <= 1'b1;
               end
            end
            DRAIN: begin
               if (last_pop) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               stb_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule
